// File: rtl/glb_bank_access_ctrl.sv
// ---------------------------------------------------------------------------
// glb_bank_access_ctrl
//   Request front-end for one GLB bank. A write stream and a tagged
//   read-request stream share the single-ported bank, and writes always win.
//   Read requests wait in a small FIFO until the bank is free. Byte strobes
//   are expanded into the bank's per-bit select. The {valid,tag} of each
//   issued read travels down a shift register that matches the bank read
//   latency, so the returning data can be paired with its tag and registered.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   wr_en/strb/addr/data      write stream (always accepted)
//   rd_req_valid/ready/addr/tag   read-request handshake
//   rd_resp_valid/data/tag    registered read response (one-cycle pulse)
//   mem_ren/mem_wen/mem_addr/mem_data_in/mem_bit_sel   bank request side
//   mem_data_out              bank read data, RD_LATENCY cycles after mem_ren
// ---------------------------------------------------------------------------
module glb_bank_access_ctrl #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int RD_LATENCY = 3,
  parameter int RDQ_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_req_addr,
  input  logic [TAG_WIDTH-1:0]    rd_req_tag,
  output logic                    rd_resp_valid,
  output logic [DATA_WIDTH-1:0]   rd_resp_data,
  output logic [TAG_WIDTH-1:0]    rd_resp_tag,
  output logic                    mem_ren,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  output logic [DATA_WIDTH-1:0]   mem_bit_sel,
  input  logic [DATA_WIDTH-1:0]   mem_data_out
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_WIDTH  = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;
  localparam int CNT_WIDTH  = $clog2(RDQ_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(RDQ_DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(RDQ_DEPTH - 1);

  // Read-request queue: circular buffer with head/tail pointers and count.
  logic [ADDR_WIDTH-1:0] q_addr_reg [RDQ_DEPTH];
  logic [TAG_WIDTH-1:0]  q_tag_reg  [RDQ_DEPTH];
  logic [PTR_WIDTH-1:0]  head_ptr_reg, head_ptr_next;
  logic [PTR_WIDTH-1:0]  tail_ptr_reg, tail_ptr_next;
  logic [CNT_WIDTH-1:0]  count_reg, count_next;

  logic                  write_act;
  logic                  issue_rd;
  logic                  push;
  logic [DATA_WIDTH-1:0] strb_mask;

  // Return pipeline: stage k holds the read issued k+1 cycles earlier.
  logic                  pipe_valid_reg [RD_LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag_reg   [RD_LATENCY];

  logic                  rd_resp_valid_reg;
  logic [DATA_WIDTH-1:0] rd_resp_data_reg;
  logic [TAG_WIDTH-1:0]  rd_resp_tag_reg;

  // Ready depends only on registered count, never on rd_req_valid.
  assign rd_req_ready = (count_reg < DEPTH_CNT);
  assign push         = rd_req_valid & rd_req_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
      assign strb_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end
  endgenerate

  // Bank issue: a write with no enabled bytes is dropped, freeing the slot
  // for a queued read.
  always_comb begin
    write_act   = wr_en & (|wr_strb);
    issue_rd    = ~write_act & (count_reg != '0);
    mem_wen     = write_act;
    mem_ren     = issue_rd;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_bit_sel = '0;
    if (write_act) begin
      mem_addr    = wr_addr;
      mem_data_in = wr_data;
      mem_bit_sel = strb_mask;
    end else if (issue_rd) begin
      mem_addr = q_addr_reg[head_ptr_reg];
    end
  end

  always_comb begin
    head_ptr_next = head_ptr_reg;
    tail_ptr_next = tail_ptr_reg;
    count_next    = count_reg;
    if (push) begin
      tail_ptr_next = (tail_ptr_reg == LAST_PTR) ? '0 : tail_ptr_reg + PTR_WIDTH'(1);
    end
    if (issue_rd) begin
      head_ptr_next = (head_ptr_reg == LAST_PTR) ? '0 : head_ptr_reg + PTR_WIDTH'(1);
    end
    case ({push, issue_rd})
      2'b10:   count_next = count_reg + CNT_WIDTH'(1);
      2'b01:   count_next = count_reg - CNT_WIDTH'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      head_ptr_reg <= head_ptr_next;
      tail_ptr_reg <= tail_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Queue storage carries no reset; entries are only read when counted.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr_reg[tail_ptr_reg] <= rd_req_addr;
      q_tag_reg[tail_ptr_reg]  <= rd_req_tag;
    end
  end

  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            pipe_valid_reg[0] <= 1'b0;
            pipe_tag_reg[0]   <= '0;
          end else begin
            pipe_valid_reg[0] <= issue_rd;
            pipe_tag_reg[0]   <= q_tag_reg[head_ptr_reg];
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            pipe_valid_reg[gi] <= 1'b0;
            pipe_tag_reg[gi]   <= '0;
          end else begin
            pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
            pipe_tag_reg[gi]   <= pipe_tag_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Last stage lines up with mem_data_out; data and tag hold between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_resp_valid_reg <= 1'b0;
      rd_resp_data_reg  <= '0;
      rd_resp_tag_reg   <= '0;
    end else begin
      rd_resp_valid_reg <= pipe_valid_reg[RD_LATENCY-1];
      if (pipe_valid_reg[RD_LATENCY-1]) begin
        rd_resp_data_reg <= mem_data_out;
        rd_resp_tag_reg  <= pipe_tag_reg[RD_LATENCY-1];
      end
    end
  end

  assign rd_resp_valid = rd_resp_valid_reg;
  assign rd_resp_data  = rd_resp_data_reg;
  assign rd_resp_tag   = rd_resp_tag_reg;

endmodule

// File: tb/tb_glb_bank_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_glb_bank_access_ctrl
//   Directed bench. A small bank emulator answers mem_* requests with a
//   fixed read latency. A transaction-level model (request queue, scheduled
//   responses, reference memory) predicts every output each cycle, and
//   literal expectations pin key points of each scenario.
// ---------------------------------------------------------------------------
module tb_glb_bank_access_ctrl;

  localparam int AW  = 17;
  localparam int DW  = 64;
  localparam int TW  = 4;
  localparam int LAT = 3;
  localparam int DEPTH = 2;
  localparam int SW  = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [SW-1:0] wr_strb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic [TW-1:0] rd_req_tag;
  logic          rd_resp_valid;
  logic [DW-1:0] rd_resp_data;
  logic [TW-1:0] rd_resp_tag;
  logic          mem_ren;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_bit_sel;
  logic [DW-1:0] mem_data_out;

  glb_bank_access_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW),
    .RD_LATENCY(LAT), .RDQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_strb(wr_strb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_req_addr(rd_req_addr), .rd_req_tag(rd_req_tag),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_tag(rd_resp_tag),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_bit_sel(mem_bit_sel), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] init_word(input int idx);
    return 64'hDEAD_BEEF_0000_0000 | 64'(idx);
  endfunction

  // ---------------- bank emulator ----------------
  // Sampled at negedge, when the DUT's combinational requests are stable.
  // A read sampled in cycle n appears on mem_data_out from the negedge of
  // cycle n+LAT, i.e. across the posedge that ends cycle n+LAT.
  logic [63:0] bank_mem [int];
  logic [63:0] bank_pipe [LAT+1];
  assign mem_data_out = bank_pipe[LAT];

  always @(negedge clk) begin
    int idx;
    logic [63:0] old;
    for (int i = LAT; i > 0; i--) bank_pipe[i] = bank_pipe[i-1];
    bank_pipe[0] = 64'h0;
    idx = int'(mem_addr >> 3);
    old = bank_mem.exists(idx) ? bank_mem[idx] : init_word(idx);
    if (mem_wen) bank_mem[idx] = (old & ~mem_bit_sel) | (mem_data_in & mem_bit_sel);
    if (mem_ren) bank_pipe[0] = old;
  end

  // ---------------- transaction model ----------------
  typedef struct { logic [AW-1:0] addr; logic [TW-1:0] tag; } req_t;
  typedef struct { int due; logic [TW-1:0] tag; logic [63:0] data; } resp_t;
  req_t        mq[$];
  resp_t       rq[$];
  logic [63:0] ref_mem [int];
  logic [63:0] last_data;
  logic [TW-1:0] last_tag;

  function automatic logic [63:0] ref_read(input int idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : init_word(idx);
  endfunction

  always @(negedge clk) begin
    bit          exp_ready;
    bit          wact;
    logic [63:0] mask;
    int          idx;
    req_t        r;
    resp_t       p;
    cyc++;
    if (reset) begin
      mq.delete();
      rq.delete();
      last_data = '0;
      last_tag  = '0;
      check("reset_ready", 64'(rd_req_ready), 64'd1);
      check("reset_resp_valid", 64'(rd_resp_valid), 64'd0);
      check("reset_resp_data", rd_resp_data, 64'd0);
      check("reset_resp_tag", 64'(rd_resp_tag), 64'd0);
      check("reset_mem_ren", 64'(mem_ren), 64'd0);
      check("reset_mem_wen", 64'(mem_wen), 64'd0);
    end else begin
      exp_ready = (mq.size() < DEPTH);
      check("rd_req_ready", 64'(rd_req_ready), 64'(exp_ready));
      wact = wr_en && (wr_strb != '0);
      mask = '0;
      for (int i = 0; i < SW; i++) if (wr_strb[i]) mask[i*8 +: 8] = 8'hFF;
      if (wact) begin
        check("mem_wen", 64'(mem_wen), 64'd1);
        check("mem_ren", 64'(mem_ren), 64'd0);
        check("mem_addr", 64'(mem_addr), 64'(wr_addr));
        check("mem_data_in", mem_data_in, wr_data);
        check("mem_bit_sel", mem_bit_sel, mask);
        idx = int'(wr_addr >> 3);
        ref_mem[idx] = (ref_read(idx) & ~mask) | (wr_data & mask);
        $display("cycle %0d WRITE addr=%h strb=%h data=%h", cyc, wr_addr, wr_strb, wr_data);
      end else if (mq.size() > 0) begin
        r = mq.pop_front();
        check("mem_wen", 64'(mem_wen), 64'd0);
        check("mem_ren", 64'(mem_ren), 64'd1);
        check("mem_addr", 64'(mem_addr), 64'(r.addr));
        p.due  = cyc + LAT + 1;
        p.tag  = r.tag;
        p.data = ref_read(int'(r.addr >> 3));
        rq.push_back(p);
        $display("cycle %0d ISSUE  addr=%h tag=%0d", cyc, r.addr, r.tag);
      end else begin
        check("idle_mem_wen", 64'(mem_wen), 64'd0);
        check("idle_mem_ren", 64'(mem_ren), 64'd0);
        check("idle_mem_addr", 64'(mem_addr), 64'd0);
        check("idle_mem_data_in", mem_data_in, 64'd0);
        check("idle_mem_bit_sel", mem_bit_sel, 64'd0);
      end
      if (rq.size() > 0 && rq[0].due == cyc) begin
        p = rq.pop_front();
        check("rd_resp_valid", 64'(rd_resp_valid), 64'd1);
        check("rd_resp_tag", 64'(rd_resp_tag), 64'(p.tag));
        check("rd_resp_data", rd_resp_data, p.data);
        last_data = p.data;
        last_tag  = p.tag;
        $display("cycle %0d RESP   tag=%0d data=%h", cyc, rd_resp_tag, rd_resp_data);
      end else begin
        check("rd_resp_valid_idle", 64'(rd_resp_valid), 64'd0);
        check("rd_resp_data_hold", rd_resp_data, last_data);
        check("rd_resp_tag_hold", 64'(rd_resp_tag), 64'(last_tag));
      end
      if (rd_req_valid && exp_ready) begin
        r.addr = rd_req_addr;
        r.tag  = rd_req_tag;
        mq.push_back(r);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en        = 1'b0;
    wr_strb      = '0;
    wr_addr      = '0;
    wr_data      = '0;
    rd_req_valid = 1'b0;
    rd_req_addr  = '0;
    rd_req_tag   = '0;
  endtask

  task automatic rd_req(input logic [AW-1:0] a, input logic [TW-1:0] t);
    rd_req_valid = 1'b1;
    rd_req_addr  = a;
    rd_req_tag   = t;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_strb = s;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    for (int i = 0; i <= LAT; i++) bank_pipe[i] = '0;
    repeat (3) tick();
    #3;
    check("lit_reset_ready", 64'(rd_req_ready), 64'd1);
    check("lit_reset_valid", 64'(rd_resp_valid), 64'd0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // 1: single read, empty queue
    rd_req(17'h40, 4'd5);
    #3 check("t1_ready", 64'(rd_req_ready), 64'd1);
    tick(); idle();
    #3;
    check("t1_ren_c1", 64'(mem_ren), 64'd1);
    check("t1_addr_c1", 64'(mem_addr), 64'h40);
    repeat (3) tick();
    #3 check("t1_valid_c4", 64'(rd_resp_valid), 64'd0);
    tick();
    #3;
    check("t1_valid_c5", 64'(rd_resp_valid), 64'd1);
    check("t1_tag", 64'(rd_resp_tag), 64'd5);
    check("t1_data", rd_resp_data, 64'hDEAD_BEEF_0000_0008);

    // 2: byte write, then read of the same word (accepted on the write cycle)
    repeat (2) tick();
    wr(17'h08, 8'b0000_0101, 64'h1122_3344_5566_7788);
    rd_req(17'h08, 4'd9);
    #3;
    check("t2_bit_sel", mem_bit_sel, 64'h0000_0000_00FF_00FF);
    check("t2_wen", 64'(mem_wen), 64'd1);
    check("t2_ren", 64'(mem_ren), 64'd0);
    tick(); idle();
    repeat (4) tick();
    #3;
    check("t2_valid", 64'(rd_resp_valid), 64'd1);
    check("t2_tag", 64'(rd_resp_tag), 64'd9);
    check("t2_data", rd_resp_data, 64'hDEAD_BEEF_0066_0088);

    // 3: write priority with a full queue
    repeat (2) tick();
    wr(17'h100, 8'hFF, 64'hAAAA_0000_0000_0001); rd_req(17'h10, 4'd1);
    tick();
    wr(17'h108, 8'hFF, 64'hAAAA_0000_0000_0002); rd_req(17'h18, 4'd2);
    tick();
    wr(17'h110, 8'hFF, 64'hAAAA_0000_0000_0003); rd_req_valid = 1'b0;
    #3;
    check("t3_ready_c2", 64'(rd_req_ready), 64'd0);
    check("t3_ren_c2", 64'(mem_ren), 64'd0);
    tick();
    wr(17'h118, 8'hFF, 64'hAAAA_0000_0000_0004);
    #3;
    check("t3_ready_c3", 64'(rd_req_ready), 64'd0);
    check("t3_ren_c3", 64'(mem_ren), 64'd0);
    tick(); idle();
    #3;
    check("t3_ren_c4", 64'(mem_ren), 64'd1);
    check("t3_addr_c4", 64'(mem_addr), 64'h10);
    tick();
    #3;
    check("t3_ren_c5", 64'(mem_ren), 64'd1);
    check("t3_addr_c5", 64'(mem_addr), 64'h18);
    check("t3_ready_c5", 64'(rd_req_ready), 64'd1);

    // 4: back-to-back reads, tags 0..7
    repeat (6) tick();
    for (int t = 0; t < 8; t++) begin
      rd_req(AW'(17'h200 + t * 8), TW'(t));
      #3 check("t4_ready", 64'(rd_req_ready), 64'd1);
      tick();
    end
    idle();

    // 5: strobe-less write does not block a queued read
    repeat (8) tick();
    wr(17'h300, 8'hFF, 64'hCCCC_DDDD_EEEE_FFFF); rd_req(17'h300, 4'd3);
    tick();
    wr(17'h308, 8'h00, 64'h1234_5678_9ABC_DEF0); rd_req_valid = 1'b0;
    #3;
    check("t5_wen", 64'(mem_wen), 64'd0);
    check("t5_ren", 64'(mem_ren), 64'd1);
    check("t5_addr", 64'(mem_addr), 64'h300);
    tick(); idle();

    // 6: reset with two queued and two in-flight reads
    repeat (6) tick();
    rd_req(17'h400, 4'd10); tick();
    rd_req(17'h408, 4'd11); tick();
    rd_req(17'h410, 4'd12); tick();
    wr(17'h500, 8'hFF, 64'h0BAD_F00D_0000_0000); rd_req(17'h418, 4'd13);
    tick(); idle();
    reset = 1'b1;
    #3;
    check("t6_ready_rst", 64'(rd_req_ready), 64'd1);
    check("t6_valid_rst", 64'(rd_resp_valid), 64'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) begin
      tick();
      #3 check("t6_valid_after", 64'(rd_resp_valid), 64'd0);
    end
    check("t6_ready_after", 64'(rd_req_ready), 64'd1);

    repeat (4) tick();
    check("all_responses_seen", 64'(rq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
